// File: rtl/des_round_sequencer.sv
// des_round_sequencer: walks one shared DES round function through
// the 16 rounds of a block, deriving each round key from C/D on the fly.
`timescale 1ns/1ps
module des_round_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_L,
   input  logic [31:0] in_R,
   input  logic [55:0] in_key,
   input  logic        in_decrypt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_L,
   output logic [31:0] out_R,
   output logic        rf_start,
   output logic [31:0] rf_L,
   output logic [31:0] rf_R,
   output logic [47:0] rf_Kn,
   input  logic        rf_done,
   input  logic [31:0] rf_L_out,
   input  logic [31:0] rf_R_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_OUTPUT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] l_q, r_q;
   logic [27:0] c_q, d_q;
   logic [3:0]  round_q;
   logic        dec_q;
   logic        accept, take, last, one_step;

   // DES bit 1 is the MSB, so "rotate left" moves bits toward [27]
   function automatic logic [27:0] rot(
      input logic [27:0] x,
      input logic        right,
      input logic        two
   );
      logic [27:0] y;
      unique case ({right, two})
         2'b00: y = {x[26:0], x[27]};
         2'b01: y = {x[25:0], x[27:26]};
         2'b10: y = {x[0], x[27:1]};
         2'b11: y = {x[1:0], x[27:2]};
      endcase
      return y;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      return {
         cd[56-14], cd[56-17], cd[56-11], cd[56-24],
         cd[56-1],  cd[56-5],  cd[56-3],  cd[56-28],
         cd[56-15], cd[56-6],  cd[56-21], cd[56-10],
         cd[56-23], cd[56-19], cd[56-12], cd[56-4],
         cd[56-26], cd[56-8],  cd[56-16], cd[56-7],
         cd[56-27], cd[56-20], cd[56-13], cd[56-2],
         cd[56-41], cd[56-52], cd[56-31], cd[56-37],
         cd[56-47], cd[56-55], cd[56-30], cd[56-40],
         cd[56-51], cd[56-45], cd[56-33], cd[56-48],
         cd[56-44], cd[56-49], cd[56-39], cd[56-56],
         cd[56-34], cd[56-53], cd[56-46], cd[56-42],
         cd[56-50], cd[56-36], cd[56-29], cd[56-32]
      };
   endfunction

   assign accept   = (state_q == S_IDLE) && in_valid;
   assign take     = (state_q == S_WAIT) && rf_done;
   assign last     = (round_q == 4'd15);
   // round_q+2 is the DES round being prepared; single shift at 2, 9, 16
   assign one_step = (round_q == 4'd0) || (round_q == 4'd7) ||
                     (round_q == 4'd14);

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      rf_start  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            rf_start = 1'b1;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (rf_done) state_d = last ? S_OUTPUT : S_ISSUE;
         end
         S_OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            l_q     <= in_L;
            r_q     <= in_R;
            dec_q   <= in_decrypt;
            round_q <= '0;
            c_q     <= in_decrypt ? in_key[55:28] :
                                    rot(in_key[55:28], 1'b0, 1'b0);
            d_q     <= in_decrypt ? in_key[27:0] :
                                    rot(in_key[27:0], 1'b0, 1'b0);
         end else if (take) begin
            l_q <= rf_L_out;
            r_q <= rf_R_out;
            if (!last) begin
               round_q <= round_q + 4'd1;
               c_q     <= rot(c_q, dec_q, !one_step);
               d_q     <= rot(d_q, dec_q, !one_step);
            end
         end
      end
   end

   assign rf_L  = l_q;
   assign rf_R  = r_q;
   assign rf_Kn = pc2({c_q, d_q});
   assign out_L = r_q;
   assign out_R = l_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// tb_des_round_sequencer: random and FIPS-vector checks of the round
// sequencer against a table-driven DES model with its own key schedule.
`timescale 1ns/1ps
module tb_des_round_sequencer;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_decrypt;
   logic        out_valid, out_ready, rf_start, rf_done;
   logic        rf_done_m, spur;
   logic [31:0] in_L, in_R, out_L, out_R;
   logic [31:0] rf_L, rf_R, rf_L_out, rf_R_out;
   logic [55:0] in_key;
   logic [47:0] rf_Kn;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_start  = 0;
   int          rf_lat   = 2;
   bit          spur_en  = 1'b0;
   logic [55:0] cur_key;
   logic        cur_dec;
   int          cur_round;
   logic [31:0] m_l, m_r;
   logic [47:0] m_k;

   always #5 clk = ~clk;
   assign rf_done = rf_done_m | spur;

   des_round_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_L      (in_L),
      .in_R      (in_R),
      .in_key    (in_key),
      .in_decrypt(in_decrypt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_L     (out_L),
      .out_R     (out_R),
      .rf_start  (rf_start),
      .rf_L      (rf_L),
      .rf_R      (rf_R),
      .rf_Kn     (rf_Kn),
      .rf_done   (rf_done),
      .rf_L_out  (rf_L_out),
      .rf_R_out  (rf_R_out)
   );

   localparam logic [0:63][3:0] SBOX [8] = '{
      256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
      256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
      256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
      256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
      256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
      256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
      256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
      256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
   };
   localparam int P_T [32] = '{
      16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
      2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
   };
   localparam int PC2_T [48] = '{
      14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
      23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
      return (x << n) | (x >> (28 - n));
   endfunction

   // Kn for DES round n (1..16), rebuilt from C0/D0 each call
   function automatic logic [47:0] key_ref(input logic [55:0] key,
                                           input int n);
      logic [27:0] c, d;
      logic [55:0] cd;
      logic [47:0] k;
      int          amt;
      c = key[55:28];
      d = key[27:0];
      for (int i = 1; i <= n; i++) begin
         amt = (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
         c = rotl(c, amt);
         d = rotl(d, amt);
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2_T[j]];
      return k;
   endfunction

   function automatic logic [31:0] f_ref(input logic [31:0] r,
                                         input logic [47:0] k);
      logic [31:0] s, p;
      logic [5:0]  six;
      int          pos;
      for (int g = 0; g < 8; g++) begin
         for (int j = 0; j < 6; j++) begin
            pos = 4 * g + j;
            if (pos == 0) pos = 32;
            else if (pos > 32) pos = pos - 32;
            six[5-j] = r[32-pos];
         end
         six = six ^ k[47-6*g -: 6];
         s[31-4*g -: 4] = SBOX[g][{six[5], six[0], six[4:1]}];
      end
      for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
      return p;
   endfunction

   function automatic logic [63:0] des_ref(input logic [31:0] l,
                                           input logic [31:0] r,
                                           input logic [55:0] key,
                                           input logic dec);
      logic [31:0] t;
      for (int j = 1; j <= 16; j++) begin
         t = l ^ f_ref(r, key_ref(key, dec ? 17 - j : j));
         l = r;
         r = t;
      end
      return {r, l};
   endfunction

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // round function: samples in ISSUE, answers rf_lat edges later
   initial begin
      rf_done_m = 1'b0;
      rf_L_out  = '0;
      rf_R_out  = '0;
      forever begin
         @(negedge clk);
         if (rf_start) begin
            m_l = rf_L;
            m_r = rf_R;
            m_k = rf_Kn;
            check("round key", m_k,
                  key_ref(cur_key, cur_dec ? 16 - cur_round : cur_round + 1));
            cur_round++;
            @(posedge clk);
            repeat (rf_lat - 1) @(posedge clk);
            #1;
            rf_L_out  = m_r;
            rf_R_out  = m_l ^ f_ref(m_r, m_k);
            rf_done_m = 1'b1;
            @(posedge clk);
            #1 rf_done_m = 1'b0;
         end
      end
   end

   initial begin
      spur = 1'b0;
      forever begin
         @(negedge clk);
         if (spur_en && (rf_start || out_valid)) begin
            spur = 1'b1;
            @(posedge clk);
            #1 spur = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rf_start) n_start++;
   end

   task automatic run_block(input logic [31:0] l, input logic [31:0] r,
                            input logic [55:0] key, input logic dec,
                            input int hold, output logic [63:0] res,
                            output logic [47:0] kn);
      int lat, s0;
      @(negedge clk);
      check("in_ready idle", in_ready, 1);
      in_L = l; in_R = r; in_key = key; in_decrypt = dec;
      in_valid = 1'b1;
      out_ready = 1'b0;
      cur_key = key; cur_dec = dec; cur_round = 0;
      s0 = n_start;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_L = $urandom; in_R = $urandom; in_decrypt = ~dec;
      check("start pulse", rf_start, 1);
      kn = rf_Kn;
      lat = 0;
      while (!out_valid && lat < 2000) begin
         @(posedge clk);
         #1 lat++;
      end
      check("latency", lat, 16 * (rf_lat + 1));
      check("start count", n_start - s0, 16);
      res = {out_L, out_R};
      check("in_ready busy", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = i[0];
         in_L = $urandom;
         check("hold data", {out_L, out_R}, res);
         check("hold valid", out_valid, 1);
         check("hold in_ready", in_ready, 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("out_valid drop", out_valid, 0);
      check("in_ready back", in_ready, 1);
   endtask

   localparam logic [55:0] FKEY = 56'hF0CCAAF556678F;

   initial begin
      logic [63:0] res, res1, tmp, exp;
      logic [47:0] kn;
      logic [31:0] l, r, l2, r2;
      logic [55:0] key, key2;
      logic        dec, bad;
      int          t, s0, edges;

      rst = 1'b1; in_valid = 1'b0; in_L = '0; in_R = '0;
      in_key = '0; in_decrypt = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst in_ready", in_ready, 1);
      check("rst out_valid", out_valid, 0);
      check("rst rf_start", rf_start, 0);
      check("rst out", {out_L, out_R}, 0);
      check("rst rf_lr", {rf_L, rf_R}, 0);
      check("rst rf_Kn", rf_Kn, 0);
      @(negedge clk) rst = 1'b0;

      run_block(32'hCC00CCFF, 32'hF0AAF0AA, FKEY, 1'b0, 0, res, kn);
      check("enc K1", kn, 48'h1B02EFFC7072);
      check("enc result", res, 64'h0A4CD99543423234);

      run_block(32'h0A4CD995, 32'h43423234, FKEY, 1'b1, 10, res, kn);
      check("dec K16", kn, 48'hCB3D8B0E17F5);
      check("dec result", res, 64'hCC00CCFFF0AAF0AA);

      rf_lat = 5;
      spur_en = 1'b1;
      run_block(32'hCC00CCFF, 32'hF0AAF0AA, FKEY, 1'b0, 3, res, kn);
      check("slow result", res, 64'h0A4CD99543423234);
      spur_en = 1'b0;
      rf_lat = 2;
      repeat (3) @(posedge clk);

      @(negedge clk);
      in_L = $urandom; in_R = $urandom; in_key = FKEY;
      in_decrypt = 1'b0; in_valid = 1'b1;
      cur_key = FKEY; cur_dec = 1'b0; cur_round = 0;
      s0 = n_start;
      @(posedge clk);
      #1 in_valid = 1'b0;
      t = 0;
      while (n_start < s0 + 7 && t < 500) begin
         @(posedge clk);
         #2 t++;
      end
      check("reach round 7", n_start - s0, 7);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid rst in_ready", in_ready, 1);
      check("mid rst out_valid", out_valid, 0);
      check("mid rst rf_start", rf_start, 0);
      check("mid rst out", {out_L, out_R}, 0);
      check("mid rst rf", {rf_L, rf_R, rf_Kn[31:0]}, 0);
      check("mid rst Kn", rf_Kn, 0);
      @(negedge clk) rst = 1'b0;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid || !in_ready) bad = 1'b1;
      end
      check("no output after rst", bad, 0);
      l = $urandom; r = $urandom;
      run_block(l, r, FKEY, 1'b0, 0, res, kn);
      check("post rst result", res, des_ref(l, r, FKEY, 1'b0));

      repeat (6) begin
         l = $urandom; r = $urandom;
         tmp = {$urandom, $urandom};
         key = tmp[55:0];
         dec = 1'($urandom_range(0, 1));
         rf_lat = $urandom_range(2, 4);
         run_block(l, r, key, dec, $urandom_range(0, 3), res, kn);
         check("rand Kn", kn, key_ref(key, dec ? 16 : 1));
         check("rand result", res, des_ref(l, r, key, dec));
      end
      rf_lat = 2;

      l = $urandom; r = $urandom; l2 = $urandom; r2 = $urandom;
      tmp = {$urandom, $urandom};
      key2 = tmp[55:0];
      @(negedge clk);
      in_L = l; in_R = r; in_key = FKEY; in_decrypt = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      cur_key = FKEY; cur_dec = 1'b0; cur_round = 0;
      @(posedge clk);
      #1;
      in_L = l2; in_R = r2; in_key = key2; in_decrypt = 1'b1;
      edges = 0;
      res1 = '0;
      while (edges < 200) begin
         @(negedge clk);
         if (out_valid) res1 = {out_L, out_R};
         if (in_ready) break;
         @(posedge clk);
         edges++;
      end
      check("b2b period", edges + 1, 50);
      check("b2b result 1", res1, des_ref(l, r, FKEY, 1'b0));
      cur_key = key2; cur_dec = 1'b1; cur_round = 0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      t = 0;
      while (!out_valid && t < 200) begin
         @(posedge clk);
         #1 t++;
      end
      check("b2b latency 2", t, 48);
      exp = des_ref(l2, r2, key2, 1'b1);
      check("b2b result 2", {out_L, out_R}, exp);
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("b2b idle", in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/des_round_sequencer.md
# des_round_sequencer

Sequences one shared `des_roundfunction` instance through the 16 rounds of a single DES block.
- Accepts a post-IP block and a post-PC-1 key.
- Generates each round key in turn: C/D rotation plus PC-2.
- Drives the round function's start/done handshake.
- Returns the pre-output block (R16‖L16) ready for the final permutation FP.
- Sits between the block-level IP/FP wrapper and the round-function datapath. Supports encrypt and decrypt.

## Interface
Parameters:
- none; 16 rounds, DES shift schedule and PC-2 are fixed (FIPS 46-3).

Ports (bit 1 = MSB, DES numbering):
- clk  in  1  clock; single clock domain, rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- in_valid  in  1  block/key/mode valid.
- in_ready  out  1  high only in IDLE.
- in_L  in  32  L0 (IP output bits 1..32).
- in_R  in  32  R0 (IP output bits 33..64).
- in_key  in  56  PC-1 output; bits 1..28 = C0, bits 29..56 = D0.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt.
- out_valid  out  1  result valid, held until taken.
- out_ready  in  1  downstream accepts result.
- out_L  out  32  R16.
- out_R  out  32  L16.
- rf_start  out  1  one-cycle start pulse to the round function.
- rf_L  out  32  current L to the round function.
- rf_R  out  32  current R to the round function.
- rf_Kn  out  48  PC-2(C,D) for the current round.
- rf_done  in  1  round-function result valid.
- rf_L_out  in  32  round-function L result.
- rf_R_out  in  32  round-function R result.

## Operation
- **State machine: IDLE → ISSUE → WAIT → (ISSUE | OUTPUT) → IDLE.**
- **IDLE:** in_ready=1. On in_valid&in_ready:
  - load L←in_L, R←in_R, mode←in_decrypt, round←0.
  - C,D ← C0,D0 shifted for round 1 (encrypt: rotate left 1; decrypt: no shift).
  - go to ISSUE.
- **ISSUE:** rf_start=1 for exactly this cycle; go to WAIT.
- **WAIT:**
  - rf_start=0; stay until rf_done=1.
  - On rf_done: L←rf_L_out, R←rf_R_out.
  - If round=15: go to OUTPUT.
  - Else: round←round+1, rotate C and D for the next round, go to ISSUE.
- **OUTPUT:**
  - out_valid=1, out_L=R, out_R=L (final swap).
  - On out_valid&out_ready: go to IDLE.
- **Shift schedule** (amount before round i = 1..16): 1 for i ∈ {1,2,9,16}, else 2.
  - Encrypt: rotate left by that amount.
  - Decrypt: rotate right, except round 1 shift = 0.
  - C and D (28 bits each) rotate independently.
- **rf_L, rf_R, rf_Kn:** driven continuously from the L/R/C/D registers; stable from ISSUE through the cycle rf_done is sampled.
- **rf_Kn:** combinational PC-2 of {C,D}.
- rf_done outside WAIT is ignored.
- in_valid outside IDLE is ignored; input ports are not sampled.
- out_L/out_R are held stable while out_valid=1 and out_ready=0.

## Timing
- **Reset** (rst high at a clock edge): state=IDLE, round=0.
  - in_ready=1, out_valid=0, rf_start=0.
  - out_L=out_R=0, rf_L=rf_R=0, rf_Kn=PC-2(0)=0; L, R, C, D cleared.
- Reset mid-operation aborts the block. No output is produced. A round function still in flight completes harmlessly; its rf_done is ignored.
- **Per-round cost:** 1 (ISSUE) + round-function latency. With the 2-cycle round function (done two edges after start is sampled) this is 3 cycles/round.
- **Latency:** out_valid rises after the 48th edge following the accepting edge. The controller adds no extra cycle.
- **Back-to-back blocks:** out handshake edge → IDLE. Next accept is the earliest following edge, so the minimum block period is 50 cycles. Input and output handshakes never overlap.
- rf_start is never reasserted before rf_done for the previous start.
- After 16 encrypt rounds, C/D have rotated 28 positions and equal C0/D0.

## Test plan
- **FIPS encrypt vector:** in_L=CC00CCFF, in_R=F0AAF0AA, in_key=F0CCAAF_556678F, decrypt=0.
  - First rf_Kn=1B02EFFC7072.
  - out_L=0A4CD995, out_R=43423234; out_valid exactly 48 edges after accept.
- **Decrypt:** in_L=0A4CD995, in_R=43423234, same key, decrypt=1.
  - First rf_Kn=K16 of the encrypt run.
  - out_L=CC00CCFF, out_R=F0AAF0AA.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid.
  - Outputs stable, in_ready=0.
  - in_valid pulses ignored.
  - Accept completes on the first out_ready=1; IDLE follows.
- **Slow round function:** model delays rf_done by 5 cycles; also inject a spurious rf_done during ISSUE/OUTPUT.
  - Same vector results.
  - Exactly 16 rf_start pulses.
  - Spurious done ignored.
- **Reset mid-block:** assert rst during round 7 WAIT.
  - Next cycle: IDLE, all outputs at reset values, no out_valid.
  - A new encrypt vector then completes correctly.
- **Back-to-back:** two blocks with out_ready tied 1.
  - Second accept occurs 50 cycles after the first.
  - Both results are correct.
